// File: rtl/tx_delay_pulser_pkg.sv
// Shared widths and FSM encoding for the TX delay pulser channels and the sequencer.
package tx_pkg;

  localparam int ADDR_WD     = 7;
  localparam int DELAY_WD    = 12;
  localparam int HALF_PER_WD = 6;
  localparam int NUM_CYC_WD  = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_DELAY  = 3'd2;
  localparam logic [2:0] ST_FIRE_P = 3'd3;
  localparam logic [2:0] ST_FIRE_N = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    DELAY  = ST_DELAY,
    FIRE_P = ST_FIRE_P,
    FIRE_N = ST_FIRE_N,
    DONE   = ST_DONE
  } tx_state_e;

  // A zero half period would give a degenerate burst; run it as one cycle per half.
  function automatic logic [HALF_PER_WD-1:0] eff_half_period(input logic [HALF_PER_WD-1:0] hp);
    return (hp == '0) ? HALF_PER_WD'(1) : hp;
  endfunction

endpackage

// File: rtl/tx_delay_pulser_if.sv
// LUT load, firing control and pulse drive bundle between sequencer and a pulser channel.
interface tx_delay_pulser_if;
  import tx_pkg::*;

  logic                   lut_we;
  logic [ADDR_WD-1:0]     lut_addr;
  logic [DELAY_WD-1:0]    lut_din;
  logic [ADDR_WD-1:0]     line_idx;
  logic                   tx_start;
  logic                   tx_abort;
  logic [HALF_PER_WD-1:0] half_period;
  logic [NUM_CYC_WD-1:0]  num_cycles;
  logic                   pulse_p;
  logic                   pulse_n;
  logic                   tx_busy;
  logic                   tx_done;

  modport master (
    output lut_we, lut_addr, lut_din, line_idx, tx_start, tx_abort, half_period, num_cycles,
    input  pulse_p, pulse_n, tx_busy, tx_done
  );

  modport slave (
    input  lut_we, lut_addr, lut_din, line_idx, tx_start, tx_abort, half_period, num_cycles,
    output pulse_p, pulse_n, tx_busy, tx_done
  );

endinterface

// File: rtl/tx_delay_pulser_lut.sv
// Focusing-delay table: simple dual-port RAM, registered read returning pre-write data.
module tx_delay_lut
  import tx_pkg::*;
#(
  parameter int AW = ADDR_WD,
  parameter int DW = DELAY_WD
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/tx_delay_pulser.sv
// Per-element TX pulser: waits the LUT focusing delay after tx_start, then emits a bipolar burst.
//   state  | meaning
//   IDLE   | waiting for tx_start
//   LOAD   | LUT read data lands in the delay counter
//   DELAY  | counting down the focusing delay
//   FIRE_P | positive half of a cycle
//   FIRE_N | negative half of a cycle
//   DONE   | one-cycle completion strobe
module tx_delay_pulser
  import tx_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  tx_delay_pulser_if.slave bus
);

  tx_state_e              state, state_nxt;
  logic [DELAY_WD-1:0]    dly_cnt, dly_cnt_nxt;
  logic [HALF_PER_WD-1:0] half_per, half_per_nxt;
  logic [HALF_PER_WD-1:0] half_cnt, half_cnt_nxt;
  logic [NUM_CYC_WD-1:0]  cyc_cnt, cyc_cnt_nxt;
  logic                   lut_re;
  logic [DELAY_WD-1:0]    lut_rdata;

  tx_delay_lut #(.AW(ADDR_WD), .DW(DELAY_WD)) u_lut (
    .clk   (clk),
    .we    (bus.lut_we),
    .waddr (bus.lut_addr),
    .wdata (bus.lut_din),
    .re    (lut_re),
    .raddr (bus.line_idx),
    .rdata (lut_rdata)
  );

  always_comb begin
    state_nxt    = state;
    dly_cnt_nxt  = dly_cnt;
    half_per_nxt = half_per;
    half_cnt_nxt = half_cnt;
    cyc_cnt_nxt  = cyc_cnt;
    lut_re       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.tx_start) begin
          lut_re       = 1'b1;
          half_per_nxt = eff_half_period(bus.half_period);
          cyc_cnt_nxt  = bus.num_cycles;
          state_nxt    = LOAD;
        end
      end
      LOAD: begin
        dly_cnt_nxt = lut_rdata;
        state_nxt   = DELAY;
      end
      DELAY: begin
        if (dly_cnt == '0) begin
          half_cnt_nxt = half_per - HALF_PER_WD'(1);
          state_nxt    = (cyc_cnt == '0) ? DONE : FIRE_P;
        end else begin
          dly_cnt_nxt = dly_cnt - DELAY_WD'(1);
        end
      end
      FIRE_P: begin
        if (half_cnt == '0) begin
          half_cnt_nxt = half_per - HALF_PER_WD'(1);
          state_nxt    = FIRE_N;
        end else begin
          half_cnt_nxt = half_cnt - HALF_PER_WD'(1);
        end
      end
      FIRE_N: begin
        if (half_cnt == '0) begin
          cyc_cnt_nxt  = cyc_cnt - NUM_CYC_WD'(1);
          half_cnt_nxt = half_per - HALF_PER_WD'(1);
          state_nxt    = (cyc_cnt == NUM_CYC_WD'(1)) ? DONE : FIRE_P;
        end else begin
          half_cnt_nxt = half_cnt - HALF_PER_WD'(1);
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && bus.tx_abort) state_nxt = IDLE;
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      dly_cnt     <= '0;
      half_per    <= '0;
      half_cnt    <= '0;
      cyc_cnt     <= '0;
      bus.pulse_p <= 1'b0;
      bus.pulse_n <= 1'b0;
      bus.tx_busy <= 1'b0;
      bus.tx_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      dly_cnt     <= dly_cnt_nxt;
      half_per    <= half_per_nxt;
      half_cnt    <= half_cnt_nxt;
      cyc_cnt     <= cyc_cnt_nxt;
      bus.pulse_p <= (state_nxt == FIRE_P);
      bus.pulse_n <= (state_nxt == FIRE_N);
      bus.tx_busy <= (state_nxt == LOAD) || (state_nxt == DELAY) ||
                     (state_nxt == FIRE_P) || (state_nxt == FIRE_N);
      bus.tx_done <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_tx_delay_pulser.sv
// Directed bench for tx_delay_pulser: per-cycle expected outputs are queued at each firing.
module tb_tx_delay_pulser;
  import tx_pkg::*;

  typedef struct packed {
    logic busy;
    logic p;
    logic n;
    logic done;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t q[$];
  int   checks;
  int   errors;
  int   cyc;
  string tag_s;

  tx_delay_pulser_if bus();

  tx_delay_pulser dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    exp_t e;
    exp_t o;
    @(posedge clk);
    #1;
    cyc++;
    e = '0;
    if (q.size() > 0) e = q.pop_front();
    o = {bus.tx_busy, bus.pulse_p, bus.pulse_n, bus.tx_done};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed busy/p/n/done=%b expected=%b", tag_s, cyc, o, e);
    end
  endtask

  // Expected outputs after edge k+j; stop_j is the edge where an abort/reset forces idle.
  task automatic push_burst(input int d, input int h, input int n, input int stop_j);
    int   he;
    int   last;
    exp_t e;
    he   = (h == 0) ? 1 : h;
    last = 2 + d + 2 * he * n;
    for (int j = 0; j <= last; j++) begin
      if (stop_j >= 0 && j >= stop_j) break;
      e = '0;
      if (j == last) begin
        e.done = 1'b1;
      end else begin
        e.busy = 1'b1;
        if (j >= 2 + d) begin
          if (((j - 2 - d) / he) % 2 == 0) e.p = 1'b1;
          else e.n = 1'b1;
        end
      end
      q.push_back(e);
    end
  endtask

  task automatic fire(input string tag, input int line, input int h, input int n,
                      input int d, input int stop_j, input logic with_abort);
    tag_s           = tag;
    bus.line_idx    = ADDR_WD'(line);
    bus.half_period = HALF_PER_WD'(h);
    bus.num_cycles  = NUM_CYC_WD'(n);
    push_burst(d, h, n, stop_j);
    bus.tx_start    = 1'b1;
    bus.tx_abort    = with_abort;
    step();
    bus.tx_start    = 1'b0;
    bus.tx_abort    = 1'b0;
  endtask

  task automatic drain();
    while (q.size() != 0) step();
    repeat (2) step();
  endtask

  task automatic wr(input int a, input int d);
    tag_s        = "lut_wr";
    bus.lut_we   = 1'b1;
    bus.lut_addr = ADDR_WD'(a);
    bus.lut_din  = DELAY_WD'(d);
    step();
    bus.lut_we   = 1'b0;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    cyc             = 0;
    tag_s           = "reset";
    rst_n           = 1'b0;
    bus.lut_we      = 1'b0;
    bus.lut_addr    = '0;
    bus.lut_din     = '0;
    bus.line_idx    = '0;
    bus.tx_start    = 1'b0;
    bus.tx_abort    = 1'b0;
    bus.half_period = '0;
    bus.num_cycles  = '0;
    repeat (3) step();
    rst_n = 1'b1;

    wr(5, 3);
    wr(1, 0);
    wr(2, 4);
    wr(3, 4095);

    fire("basic_d3_h2_n2", 5, 2, 2, 3, -1, 1'b0);
    drain();
    fire("d0_h1_n1", 1, 1, 1, 0, -1, 1'b0);
    drain();
    fire("h0_as_h1", 1, 0, 1, 0, -1, 1'b0);
    drain();
    fire("n0_d4", 2, 3, 0, 4, -1, 1'b0);
    drain();

    // Abort lands on the second FIRE_P; a new start follows immediately.
    fire("abort_fire_p", 1, 2, 2, 0, 7, 1'b0);
    repeat (6) step();
    tag_s        = "abort_edge";
    bus.tx_abort = 1'b1;
    step();
    bus.tx_abort = 1'b0;
    fire("restart_after_abort", 5, 1, 1, 3, -1, 1'b0);
    drain();

    fire("start_beats_abort", 1, 1, 1, 0, -1, 1'b1);
    drain();

    fire("ignore_start", 2, 1, 1, 4, -1, 1'b0);
    repeat (2) step();
    bus.line_idx = ADDR_WD'(1);
    bus.tx_start = 1'b1;
    step();
    bus.tx_start = 1'b0;
    repeat (5) step();
    tag_s        = "ignore_start_done";
    bus.tx_start = 1'b1;
    step();
    bus.tx_start = 1'b0;
    drain();

    fire("reset_fire_n", 1, 2, 1, 0, 5, 1'b0);
    repeat (4) step();
    tag_s = "reset_edge";
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drain();

    bus.lut_we   = 1'b1;
    bus.lut_addr = ADDR_WD'(5);
    bus.lut_din  = DELAY_WD'(9);
    fire("same_edge_old", 5, 1, 1, 3, -1, 1'b0);
    bus.lut_we   = 1'b0;
    drain();
    fire("same_edge_new", 5, 1, 1, 9, -1, 1'b0);
    drain();

    fire("max_delay", 3, 1, 1, 4095, -1, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
